booth_mult_32: RTL and testbench

//  Multi-cycle 32x32 signed multiplier using radix-2 Booth recoding. It sits downstream of the
//  32-bit carry-select adder (csa_32) and reuses a single csa_32 instance once per cycle for the
//  add/subtract step. It delivers the low 32 bits of the product plus an overflow exception to
//  the processor's multdiv/writeback path through a start/ready handshake.

---
 rtl/booth_mult_32_pkg.sv | 28 ++
 rtl/booth_mult_32_step.sv | 93 +++++++++
 rtl/booth_mult_32.sv | 104 ++++++++++
 tb/tb_booth_mult_32.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/booth_mult_32_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: widths, FSM state
// encodings and the Booth recode helper.
package booth_mult_32_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = 6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // {Q[0], q_1}: 01 -> +M, 10 -> -M, 00/11 -> nothing
    function automatic booth_op_t booth_recode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_mult_32_step.sv
// One Booth iteration (combinational) plus the 32-bit carry-select adder it
// uses.
//
// csa_32 ports:
//   a, b   in  32  addends
//   ci     in  1   carry in
//   s      out 32  sum
//   ovf    out 1   signed overflow of a + b + ci
//
// booth_step ports:
//   a         in  32  accumulator (upper half of P)
//   m         in  32  multiplicand
//   q0, q_1   in  1   recode pair {Q[0], q_1}
//   a_next    out 32  accumulator after add and arithmetic shift
//   shift_in  out 1   bit shifted into Q[31]
//   q_1_next  out 1   next q_1 (old Q[0])

module csa_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        ovf
);
    logic [8:0] lo;
    logic [3:0] c;

    assign lo    = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, ci};
    assign s[7:0] = lo[7:0];
    assign c[0]   = lo[8];

    // Upper blocks precompute both carry-in cases and select on the
    // incoming block carry.
    for (genvar g = 1; g < 4; g++) begin : g_blk
        logic [8:0] s0;
        logic [8:0] s1;
        assign s0 = {1'b0, a[g*8 +: 8]} + {1'b0, b[g*8 +: 8]};
        assign s1 = {1'b0, a[g*8 +: 8]} + {1'b0, b[g*8 +: 8]} + 9'd1;
        assign s[g*8 +: 8] = c[g-1] ? s1[7:0] : s0[7:0];
        assign c[g]        = c[g-1] ? s1[8]   : s0[8];
    end

    // Carry into bit 31 is recovered as a^b^s at that bit.
    assign ovf = c[3] ^ (a[31] ^ b[31] ^ s[31]);
endmodule

module booth_step
    import booth_mult_32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] m,
    input  logic        q0,
    input  logic        q_1,
    output logic [31:0] a_next,
    output logic        shift_in,
    output logic        q_1_next
);
    booth_op_t   op;
    logic [31:0] addend;
    logic        ci;
    logic [31:0] sum;
    logic        ovf;
    logic        sgn;

    assign op = booth_recode(q0, q_1);

    always_comb begin
        addend = '0;
        ci     = 1'b0;
        case (op)
            BOOTH_ADD: addend = m;
            BOOTH_SUB: begin
                addend = ~m;
                ci     = 1'b1;
            end
            default: ;
        endcase
    end

    csa_32 u_csa (
        .a   (a),
        .b   (addend),
        .ci  (ci),
        .s   (sum),
        .ovf (ovf)
    );

    // The 33-bit true sum's sign; keeps M = 0x80000000 exact.
    assign sgn      = sum[31] ^ ovf;
    assign a_next   = {sgn, sum[31:1]};
    assign shift_in = sum[0];
    assign q_1_next = q0;
endmodule

// File: rtl/booth_mult_32.sv
// Multi-cycle 32x32 signed radix-2 Booth multiplier, low-word result plus
// overflow flag, start/ready handshake.
//
// Ports:
//   clock           in  1   rising-edge clock
//   reset           in  1   async active-high reset
//   ctrl_MULT       in  1   start pulse, operands sampled the same cycle
//   data_operandA   in  32  multiplicand
//   data_operandB   in  32  multiplier
//   data_result     out 32  product[31:0], held until next completion
//   data_exception  out 1   product does not fit in 32 signed bits
//   data_resultRDY  out 1   one-cycle pulse when the result updates
//   busy            out 1   high while iterating
//
// state | meaning
// IDLE  | waiting for ctrl_MULT
// RUN   | one Booth iteration per clock, 32 total
// DONE  | result valid pulse; ctrl_MULT here restarts immediately

module booth_mult_32
    import booth_mult_32_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [31:0]      m_reg;
    logic [31:0]      a_reg;
    logic [31:0]      q_reg;
    logic             q_1_reg;

    logic [31:0] a_next;
    logic        shift_in;
    logic        q_1_next;
    logic [31:0] q_next;
    logic        last;

    booth_step u_step (
        .a        (a_reg),
        .m        (m_reg),
        .q0       (q_reg[0]),
        .q_1      (q_1_reg),
        .a_next   (a_next),
        .shift_in (shift_in),
        .q_1_next (q_1_next)
    );

    assign q_next = {shift_in, q_reg[31:1]};
    assign last   = (state == RUN) && (count == CNT_W'(ITERS - 1));
    assign busy   = (state == RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            m_reg          <= '0;
            a_reg          <= '0;
            q_reg          <= '0;
            q_1_reg        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ctrl_MULT) begin
                        m_reg   <= data_operandA;
                        a_reg   <= '0;
                        q_reg   <= data_operandB;
                        q_1_reg <= 1'b0;
                        count   <= '0;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_reg   <= a_next;
                    q_reg   <= q_next;
                    q_1_reg <= q_1_next;
                    count   <= count + 1'b1;
                    // Outputs are captured from the final shift so they are
                    // valid throughout the DONE cycle.
                    if (last) begin
                        state          <= DONE;
                        data_resultRDY <= 1'b1;
                        data_result    <= q_next;
                        data_exception <= (a_next != {32{shift_in}});
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_32.sv
module tb_booth_mult_32;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int passed = 0;
    int total  = 0;

    booth_mult_32 dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    // Called at a negative edge: the start is sampled at the next rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
    endtask

    // Waits for RDY after an issue(); leaves time at the DONE-cycle negedge.
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic exp_exc);
        int c;
        c = 0;
        do begin
            @(negedge clock);
            c++;
            if (c == 1) begin
                ctrl_MULT     = 1'b0;
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
        end while (!data_resultRDY && c < 100);
        check({tag, "_lat"}, c, 33);
        check({tag, "_res"}, data_result, exp_res);
        check1({tag, "_exc"}, data_exception, exp_exc);
    endtask

    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic exp_exc);
        issue(a, b);
        wait_done(tag, exp_res, exp_exc);
        @(negedge clock);
        check1({tag, "_pulse"}, data_resultRDY, 1'b0);
        check({tag, "_hold"}, data_result, exp_res);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        longint      prod;
        logic        saw_rdy;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_res", data_result, 32'h0);
        check1("rst_exc", data_exception, 1'b0);
        check1("rst_rdy", data_resultRDY, 1'b0);
        check1("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // 1: 3 * -5
        run_check("t1", 32'd3, 32'hFFFFFFFB, 32'hFFFFFFF1, 1'b0);
        // 2: most-negative multiplicand
        run_check("t2a", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
        run_check("t2b", 32'h80000000, 32'h00000001, 32'h80000000, 1'b0);
        // 3: overflow / max positive
        run_check("t3a", 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        run_check("t3b", 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0);

        // 4: start while running is ignored; busy profile
        issue(32'd6, 32'd7);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clock);
            check1("t4_busy", busy, (c <= 32));
            check1("t4_rdy", data_resultRDY, (c == 33));
            if (c == 1) ctrl_MULT = 1'b0;
            if (c == 10) begin
                ctrl_MULT     = 1'b1;
                data_operandA = 32'd9;
                data_operandB = 32'd9;
            end
            if (c == 11) ctrl_MULT = 1'b0;
        end
        check("t4_res", data_result, 32'd42);
        check1("t4_exc", data_exception, 1'b0);
        @(negedge clock);
        check1("t4_idle", busy, 1'b0);

        // 5: reset mid-run
        issue(32'd6, 32'd7);
        repeat (15) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
        end
        reset = 1'b1;
        #1;
        check1("t5_busy_rst", busy, 1'b0);
        check("t5_res_rst", data_result, 32'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        saw_rdy = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) saw_rdy = 1'b1;
        end
        check1("t5_no_rdy", saw_rdy, 1'b0);
        check("t5_res", data_result, 32'h0);
        check1("t5_exc", data_exception, 1'b0);
        check1("t5_busy", busy, 1'b0);
        run_check("t5_new", 32'd11, 32'd13, 32'd143, 1'b0);

        // 6: back-to-back restart from DONE
        issue(32'd6, 32'd7);
        wait_done("t6a", 32'd42, 1'b0);
        issue(32'hFFFFFFFE, 32'hFFFFFFFD);
        wait_done("t6b", 32'd6, 1'b0);
        @(negedge clock);
        check1("t6_pulse", data_resultRDY, 1'b0);

        // Random signed pairs against a 64-bit golden product
        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            prod = longint'($signed(ra)) * longint'($signed(rb));
            issue(ra, rb);
            wait_done("rnd", prod[31:0], (prod[63:32] != {32{prod[31]}}));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
